// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the execute-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

  localparam logic [DEF_WIDTH-1:0] DIVZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or restoring
// divide step on the {hi, lo} accumulator pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
    shifted = {hi_in, lo_in[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      // diff[WIDTH] is the borrow: set means the trial subtract must be undone
      if (!diff[WIDTH]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = shifted[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Optional MTHI/MTLO write ports are built when MULDIV_MTHILO_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for StartE; HI/LO hold
// S_MUL  | 32 shift-add steps on operand magnitudes
// S_DIV  | 32 restoring-divide steps on operand magnitudes
// S_FIX  | sign correction, HI/LO writeback, DoneE next cycle
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
`ifdef MULDIV_MTHILO_EN
  input  logic             HiWEE,
  input  logic             LoWEE,
  input  logic [WIDTH-1:0] WDataE,
`endif
  output logic             BusyE,
  output logic             DoneE,
  output logic             DivZeroE,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(ITER + 1);

  state_e           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic             is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic             start_div, start_signed, start_zero, a_neg, b_neg, last_step;

  assign start_div    = (OpE == OP_DIVU) || (OpE == OP_DIV);
  assign start_signed = (OpE == OP_MULT) || (OpE == OP_DIV);
  assign start_zero   = start_div && (SrcBE == '0);
  assign a_neg        = start_signed && SrcAE[WIDTH-1];
  assign b_neg        = start_signed && SrcBE[WIDTH-1];
  assign last_step    = (cnt == CW'(ITER - 1));
  assign BusyE        = (state != S_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == S_DIV),
    .hi_in    (acc_hi),
    .lo_in    (acc_lo),
    .operand  (opnd_b),
    .hi_out   (step_hi),
    .lo_out   (step_lo)
  );

  always_ff @(posedge CLK) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (StartE) state_nx = start_zero ? S_FIX : (start_div ? S_DIV : S_MUL);
      S_MUL,
      S_DIV:  if (last_step) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (div_zero) begin
      // acc_lo carries the raw dividend on this path
      fix_hi = acc_lo;
      fix_lo = DIVZERO_LO;
    end else if (is_div) begin
      fix_hi = neg_rem ? -acc_hi : acc_hi;
      fix_lo = neg_res ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      HiOut    <= '0;
      LoOut    <= '0;
      DoneE    <= 1'b0;
      DivZeroE <= 1'b0;
    end else begin
      DoneE    <= 1'b0;
      DivZeroE <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef MULDIV_MTHILO_EN
          if (HiWEE) HiOut <= WDataE;
          if (LoWEE) LoOut <= WDataE;
`endif
          if (StartE) begin
            is_div   <= start_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= start_zero;
            acc_hi   <= '0;
            acc_lo   <= (a_neg && !start_zero) ? -SrcAE : SrcAE;
            opnd_b   <= b_neg ? -SrcBE : SrcBE;
            cnt      <= '0;
          end
        end
        S_MUL,
        S_DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
        end
        S_FIX: begin
          HiOut    <= fix_hi;
          LoOut    <= fix_lo;
          DoneE    <= 1'b1;
          DivZeroE <= div_zero;
          cnt      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: vector table plus scoreboard of
// expected HI/LO/DivZeroE and completion cycle, with hand sequences for corner cases.
module tb_execute_muldiv;
  import muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR, StartE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE, DivZeroE;
  logic [31:0] HiOut, LoOut;
`ifdef MULDIV_MTHILO_EN
  logic        HiWEE = 1'b0, LoWEE = 1'b0;
  logic [31:0] WDataE = '0;
`endif

  always #5 CLK = ~CLK;

  execute_muldiv dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .StartE   (StartE),
    .OpE      (OpE),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
`ifdef MULDIV_MTHILO_EN
    .HiWEE    (HiWEE),
    .LoWEE    (LoWEE),
    .WDataE   (WDataE),
`endif
    .BusyE    (BusyE),
    .DoneE    (DoneE),
    .DivZeroE (DivZeroE),
    .HiOut    (HiOut),
    .LoOut    (LoOut)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    dz = 1'b0;
    p  = '0;
    if (op == OP_MULTU) p = {32'b0, a} * {32'b0, b};
    if (op == OP_MULT)  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    {hi, lo} = p;
    if (op[1]) begin
      if (b == 0) begin
        hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
      end else if (op == OP_DIVU) begin
        lo = a / b; hi = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000; hi = 0;
      end else begin
        lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b);
      end
    end
  endfunction

  always @(negedge CLK) begin
    if (DivZeroE && !DoneE) begin
      n_vec++; n_err++;
      $display("FAIL divzero_without_done: DivZeroE=1 required 0");
    end
    if (DoneE) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: DoneE=1 required 0 at cycle %0d", cyc);
      end else begin
        got = sb.pop_front();
        check("hi", HiOut, got.hi);
        check("lo", LoOut, got.lo);
        check("divzero", DivZeroE, got.dz);
        check("done_cycle", cyc, got.done_cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    OpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
    if (push) begin
      e.hi = hi; e.lo = lo; e.dz = dz;
      e.done_cyc = cyc + 1 + ((op[1] && b == 0) ? 1 : 33);
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    @(posedge CLK); #1;
    drive(op, a, b, push, hi, lo, dz);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge CLK);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: %0d results pending required 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h, l, a, b;
    logic [1:0]  op;
    logic        dz;
    int          busy;

    tbl = '{
      '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
      '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0},
      '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0},
      '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
      '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0},
      '{OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1},
      '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1},
      '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0},
      '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0},
      '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0}
    };

    CLR = 1'b1; StartE = 1'b0; OpE = '0; SrcAE = '0; SrcBE = '0;
    repeat (3) @(posedge CLK);
    #1 CLR = 1'b0;
    @(negedge CLK);
    check("reset_busy", BusyE, 0);
    check("reset_done", DoneE, 0);
    check("reset_divzero", DivZeroE, 0);
    check("reset_hi", HiOut, 0);
    check("reset_lo", LoOut, 0);

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].hi, tbl[i].lo, tbl[i].dz);
      if (i == 0) begin
        busy = 0;
        repeat (40) begin
          @(negedge CLK);
          if (BusyE) busy++;
        end
        check("busy_cycles", busy, 33);
      end
      drain();
    end

    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (i[0] ? $urandom : 32'($urandom_range(1, 1000)));
      model(op, a, b, h, l, dz);
      start_op(op, a, b, 1'b1, h, l, dz);
      drain();
    end

    // StartE while busy must be ignored
    start_op(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    repeat (4) @(posedge CLK);
    #1 OpE = OP_MULTU; SrcAE = 32'd9; SrcBE = 32'd9; StartE = 1'b1;
    @(posedge CLK); #1 StartE = 1'b0;
    drain();
    repeat (40) @(posedge CLK);

    // CLR mid-operation aborts and clears HI/LO
    start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, 0);
    repeat (9) @(posedge CLK);
    #1 CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
    @(negedge CLK);
    check("clr_busy", BusyE, 0);
    check("clr_hi", HiOut, 0);
    check("clr_lo", LoOut, 0);
    repeat (40) @(posedge CLK);
    start_op(OP_MULTU, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0);
    drain();

    // back-to-back: new StartE in the DoneE cycle
    start_op(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    repeat (33) @(posedge CLK);
    #1 check("b2b_done_cycle", DoneE, 1);
    drive(OP_MULTU, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, 1'b0);
    drain();
    repeat (5) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline register. It takes that register's forwarded operands and a start pulse, runs a 32-step shift-add multiply or restoring divide, and writes the architectural HI/LO pair. BusyE feeds the hazard unit, which stalls fetch/decode and clears the decode/execute register while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits.
ITER, 32, iteration steps per operation; must equal WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
CLR  input  1  synchronous active-high reset.
StartE  input  1  request a new operation; sampled only in IDLE.
OpE  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
SrcAE  input  WIDTH  multiplicand / dividend.
SrcBE  input  WIDTH  multiplier / divisor.
BusyE  output  1  high whenever state != IDLE (combinational from state).
DoneE  output  1  one-cycle pulse; HI/LO are updated and valid in the same cycle.
DivZeroE  output  1  pulses with DoneE when a DIV/DIVU had divisor 0.
HiOut  output  WIDTH  HI register.
LoOut  output  WIDTH  LO register.

Behaviour:
- Reset: CLR is synchronous and active-high, and has priority over all other inputs. On reset: state = IDLE, BusyE = 0, DoneE = 0, DivZeroE = 0, HiOut = 0, LoOut = 0, step counter = 0.
- Reset mid-operation aborts the operation. No DoneE pulse is produced and HI/LO are cleared.
- States and transitions:
  - IDLE: StartE = 1 at edge E0 latches the operand magnitudes, the operand signs and OpE. Next state is MUL or DIV. For DIV/DIVU with SrcBE = 0, next state is FIX directly.
  - MUL/DIV: one step per edge. The counter increments each step. After step 32 (edge E32), go to FIX.
  - FIX: at edge E33, apply the sign correction, write HI/LO, assert DoneE for the following cycle, and return to IDLE.
- Latency: DoneE is high in the cycle after E33, i.e. 33 edges after acceptance. BusyE is high for exactly 33 cycles. Divide-by-zero: DoneE is high after E1.
- StartE while BusyE = 1 is ignored; the operand inputs are don't-care.
- StartE in the DoneE cycle is accepted, because the state is already IDLE. This gives back-to-back operation.
- Signed operations use absolute values. The 64-bit product is negated when the operand signs differ. The quotient is negated when the signs differ. The remainder takes the dividend's sign.
- Unsigned operations skip all sign handling.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap is raised.
- Divide by zero gives LO = 0xFFFFFFFF, HI = SrcAE as captured, and DivZeroE = 1.
- Multiply result: HI = product[63:32], LO = product[31:0]. Divide result: LO = quotient, HI = remainder.
- HI/LO hold their values between operations.
- DoneE and DivZeroE are registered and are low in every cycle other than the completion pulse.

Optional Feature:
MULDIV_MTHILO_EN
- Defined: adds input ports HiWEE (1), LoWEE (1) and WDataE (WIDTH) to implement MTHI/MTLO.
  - In IDLE, a write enable loads WDataE into HI or LO at the next edge.
  - A write while BusyE = 1 is ignored, and the FIX writeback takes precedence.
  - A write and StartE in the same IDLE cycle both take effect; the later completion overwrites the written value.
- Undefined: these ports are absent, and HI/LO are written only by completion and reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - the OpE encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state encoding (S_IDLE, S_MUL, S_DIV, S_FIX);
  - WIDTH and ITER defaults;
  - the divide-by-zero LO constant 0xFFFFFFFF.
- One sub-module, muldiv_step: a combinational single-iteration datapath (shift-add or trial-subtract) selected by mode. The FSM, counter and HI/LO registers stay in execute_muldiv.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; DoneE exactly 33 edges after acceptance; BusyE high for 33 cycles.
2. MULT -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIVU 100 / 7 -> LO = 14, HI = 2.
3. DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, DivZeroE = 0.
4. DIV 0x12345678 / 0 -> DoneE and DivZeroE high after E1; LO = 0xFFFFFFFF, HI = 0x12345678.
5. StartE asserted at step 5 with other operands -> ignored, first result unchanged. CLR at step 10 -> next cycle BusyE = 0, HI = LO = 0, no DoneE; a new StartE is then accepted.
6. StartE in the DoneE cycle (MULTU 2 x 3 after DIVU 100 / 7) -> first result visible, second accepted; HI = 0, LO = 6 exactly 33 edges later.
